// File: rtl/grap_rd_pkg.sv
// Shared definitions for the graphics read pipe: memory-mode encodings,
// FSM state type and parameter legality helpers.
package grap_rd_pkg;

    localparam logic [1:0] MM_PLANAR = 2'b00;
    localparam logic [1:0] MM_OE8    = 2'b01;
    localparam logic [1:0] MM_OE16   = 2'b10;
    localparam logic [1:0] MM_CHAIN4 = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } rd_state_t;

    function automatic bit nplanes_legal(input int n);
        return (n == 2) || (n == 4) || (n == 8);
    endfunction

    function automatic bit depth_legal(input int d);
        return (d >= 1) && (d <= 8);
    endfunction

endpackage

// File: rtl/grap_rd_fifo.sv
// Shift-style return FIFO: the head is always slot 0, pops shift the rest down.
module grap_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       mem_clk,
    input  logic                       hreset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH*WIDTH-1:0] store;
    logic [DEPTH*WIDTH-1:0] store_nxt;
    logic                   do_pop;
    logic                   do_push;
    logic [CW-1:0]          wr_idx;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign wr_idx  = count - CW'(do_pop);
    assign dout    = store[WIDTH-1:0];

    // A simultaneous push lands in the slot the shifted contents just freed.
    always_comb begin
        store_nxt = do_pop ? (store >> WIDTH) : store;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (wr_idx == CW'(i))) begin
                store_nxt[i*WIDTH +: WIDTH] = din;
            end
        end
    end

    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            store <= '0;
            count <= '0;
        end else begin
            store <= store_nxt;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/grap_rd_pipe.sv
// Graphics memory read pipe: one outstanding request, CPU data latch,
// read-mode formatting and a small host return FIFO.
module grap_rd_pipe
    import grap_rd_pkg::*;
#(
    parameter int NPLANES = 4,
    parameter int PW      = 8,
    parameter int DEPTH   = 2
) (
    input  logic                       mem_clk,
    input  logic                       hreset_n,
    input  logic                       rd_req,
    output logic                       rd_req_rdy,
    input  logic                       rd_mode,
    input  logic [1:0]                 mem_mode,
    input  logic [$clog2(NPLANES)-1:0] map_sel,
    input  logic                       addr_lo,
    input  logic [NPLANES-1:0]         cc_color,
    input  logic [NPLANES-1:0]         cc_care,
    input  logic                       mem_rd_valid,
    input  logic [NPLANES*PW-1:0]      mem_rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NPLANES*PW-1:0]      out_data,
    output logic [NPLANES*PW-1:0]      cpu_lat_data,
    output logic [PW-1:0]              crt_rd_data,
    output logic                       busy,
    output logic                       rd_err
);

    localparam int W  = NPLANES * PW;
    localparam int SW = $clog2(NPLANES);
    localparam int CW = $clog2(DEPTH + 1);

    if (!nplanes_legal(NPLANES) || !depth_legal(DEPTH)) begin : g_bad_params
        $error("grap_rd_pipe: illegal NPLANES or DEPTH");
    end

    rd_state_t     state;
    rd_state_t     state_nxt;
    logic [CW-1:0] fifo_count;
    logic          capture;
    logic          stray;
    logic [W-1:0]  fmt_data;
    logic [PW-1:0] planes     [NPLANES];
    logic [PW-1:0] lat_planes [NPLANES];
    logic [PW-1:0] cmp_byte;
    logic          bit_ok;
    logic [SW-1:0] lo_idx;
    logic [SW-1:0] hi_idx;
    logic [SW-1:0] sel8;

    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (rd_req && rd_req_rdy) state_nxt = ST_WAIT;
            ST_WAIT: if (mem_rd_valid)         state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Accepting only when a FIFO slot is free reserves room for the return data.
    always_comb begin
        rd_req_rdy = 1'b0;
        busy       = 1'b0;
        capture    = 1'b0;
        stray      = 1'b0;
        case (state)
            ST_IDLE: begin
                rd_req_rdy = (fifo_count < CW'(DEPTH));
                stray      = mem_rd_valid;
            end
            ST_WAIT: begin
                busy    = 1'b1;
                capture = mem_rd_valid;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int p = 0; p < NPLANES; p++) begin
            planes[p]     = mem_rd_data[p*PW +: PW];
            lat_planes[p] = cpu_lat_data[p*PW +: PW];
        end
    end

    assign lo_idx = map_sel & ~SW'(1);
    assign hi_idx = lo_idx | SW'(1);
    assign sel8   = lo_idx | SW'(addr_lo);

    // Colour compare: a pixel bit is set when every cared-about plane matches.
    always_comb begin
        cmp_byte = '0;
        bit_ok   = 1'b1;
        for (int i = 0; i < PW; i++) begin
            bit_ok = 1'b1;
            for (int p = 0; p < NPLANES; p++) begin
                bit_ok = bit_ok & (~cc_care[p] | ~(planes[p][i] ^ cc_color[p]));
            end
            cmp_byte[i] = bit_ok;
        end
    end

    always_comb begin
        fmt_data = mem_rd_data;
        for (int p = 0; p < NPLANES; p++) begin
            if (rd_mode) begin
                fmt_data[p*PW +: PW] = cmp_byte;
            end else begin
                case (mem_mode)
                    MM_PLANAR: fmt_data[p*PW +: PW] = planes[map_sel];
                    MM_OE8:    fmt_data[p*PW +: PW] = planes[sel8];
                    MM_OE16:   fmt_data[p*PW +: PW] = (p % 2 == 1) ? planes[hi_idx] : planes[lo_idx];
                    default:   fmt_data[p*PW +: PW] = planes[p];
                endcase
            end
        end
    end

    // Returns arriving with nothing outstanding are dropped and flagged.
    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            cpu_lat_data <= '0;
            rd_err       <= 1'b0;
        end else begin
            if (capture) cpu_lat_data <= mem_rd_data;
            if (stray)   rd_err       <= 1'b1;
        end
    end

    assign crt_rd_data = lat_planes[map_sel];
    assign out_valid   = (fifo_count != '0);

    grap_rd_fifo #(
        .WIDTH(W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .mem_clk (mem_clk),
        .hreset_n(hreset_n),
        .push    (capture),
        .din     (fmt_data),
        .pop     (out_ready),
        .dout    (out_data),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_grap_rd_pipe.sv
// Directed self-checking bench for grap_rd_pipe at NPLANES=4, PW=8, DEPTH=2.
module tb_grap_rd_pipe;
    import grap_rd_pkg::*;

    logic        mem_clk;
    logic        hreset_n;
    logic        rd_req;
    logic        rd_req_rdy;
    logic        rd_mode;
    logic [1:0]  mem_mode;
    logic [1:0]  map_sel;
    logic        addr_lo;
    logic [3:0]  cc_color;
    logic [3:0]  cc_care;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] cpu_lat_data;
    logic [7:0]  crt_rd_data;
    logic        busy;
    logic        rd_err;

    int vecCount = 0;
    int errCount = 0;

    grap_rd_pipe #(.NPLANES(4), .PW(8), .DEPTH(2)) dut (
        .mem_clk     (mem_clk),
        .hreset_n    (hreset_n),
        .rd_req      (rd_req),
        .rd_req_rdy  (rd_req_rdy),
        .rd_mode     (rd_mode),
        .mem_mode    (mem_mode),
        .map_sel     (map_sel),
        .addr_lo     (addr_lo),
        .cc_color    (cc_color),
        .cc_care     (cc_care),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .cpu_lat_data(cpu_lat_data),
        .crt_rd_data (crt_rd_data),
        .busy        (busy),
        .rd_err      (rd_err)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One complete read: request with misleading mode inputs, then return data
    // with the real ones, since modes must be taken at the return edge.
    task automatic applyStimulus(input logic mode, input logic [1:0] mm, input logic [1:0] ms,
                                 input logic al, input logic [31:0] data, input logic popAtValid);
        int n = 0;
        while (!rd_req_rdy && n < 20) begin
            @(posedge mem_clk); #1;
            n++;
        end
        checkOutput("rdy_wait", rd_req_rdy, 1);
        rd_req   = 1'b1;
        rd_mode  = ~mode;
        mem_mode = ~mm;
        map_sel  = ms;
        addr_lo  = ~al;
        @(posedge mem_clk); #1;
        rd_req = 1'b0;
        checkOutput("busy_wait", busy, 1);
        rd_mode      = mode;
        mem_mode     = mm;
        addr_lo      = al;
        mem_rd_data  = data;
        mem_rd_valid = 1'b1;
        out_ready    = popAtValid;
        @(posedge mem_clk); #1;
        mem_rd_valid = 1'b0;
        out_ready    = 1'b0;
        mem_rd_data  = 32'hA5A5_A5A5;
        checkOutput("busy_done", busy, 0);
    endtask

    task automatic popOne();
        out_ready = 1'b1;
        @(posedge mem_clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        hreset_n     = 1'b0;
        rd_req       = 1'b0;
        rd_mode      = 1'b0;
        mem_mode     = MM_PLANAR;
        map_sel      = 2'd0;
        addr_lo      = 1'b0;
        cc_color     = 4'b0000;
        cc_care      = 4'b0000;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 32'h0;
        out_ready    = 1'b0;

        #12;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_cpu_lat", cpu_lat_data, 32'h0);
        checkOutput("rst_rd_err", rd_err, 0);
        checkOutput("rst_busy", busy, 0);
        @(posedge mem_clk); #1;
        hreset_n = 1'b1;
        @(posedge mem_clk); #1;
        checkOutput("rst_rdy", rd_req_rdy, 1);

        $display("[TB] planar and latch");
        applyStimulus(1'b0, MM_PLANAR, 2'd2, 1'b0, 32'h4433_2211, 1'b0);
        checkOutput("planar_valid", out_valid, 1);
        checkOutput("planar_data", out_data, 32'h3333_3333);
        checkOutput("planar_lat", cpu_lat_data, 32'h4433_2211);
        checkOutput("planar_crt", crt_rd_data, 32'h33);
        popOne();
        checkOutput("planar_empty", out_valid, 0);
        checkOutput("lat_hold", cpu_lat_data, 32'h4433_2211);

        $display("[TB] colour compare");
        cc_color = 4'b0101;
        cc_care  = 4'b1111;
        applyStimulus(1'b1, MM_CHAIN4, 2'd0, 1'b0, 32'h00FF_00FF, 1'b0);
        checkOutput("cc_match", out_data, 32'hFFFF_FFFF);
        popOne();
        applyStimulus(1'b1, MM_PLANAR, 2'd0, 1'b0, 32'h0000_0000, 1'b0);
        checkOutput("cc_nomatch", out_data, 32'h0000_0000);
        checkOutput("cc_lat", cpu_lat_data, 32'h0000_0000);
        popOne();
        cc_care = 4'b0000;
        applyStimulus(1'b1, MM_PLANAR, 2'd0, 1'b0, 32'h0000_0000, 1'b0);
        checkOutput("cc_dontcare", out_data, 32'hFFFF_FFFF);
        popOne();

        $display("[TB] odd/even and chain4");
        applyStimulus(1'b0, MM_OE16, 2'd2, 1'b0, 32'h4433_2211, 1'b0);
        checkOutput("oe16", out_data, 32'h4433_4433);
        popOne();
        applyStimulus(1'b0, MM_OE8, 2'd2, 1'b1, 32'h4433_2211, 1'b0);
        checkOutput("oe8_odd", out_data, 32'h4444_4444);
        popOne();
        applyStimulus(1'b0, MM_OE8, 2'd3, 1'b0, 32'h4433_2211, 1'b0);
        checkOutput("oe8_even", out_data, 32'h3333_3333);
        popOne();
        applyStimulus(1'b0, MM_CHAIN4, 2'd1, 1'b0, 32'h4433_2211, 1'b0);
        checkOutput("chain4", out_data, 32'h4433_2211);
        popOne();

        $display("[TB] fifo depth and ordering");
        applyStimulus(1'b0, MM_PLANAR, 2'd0, 1'b0, 32'h0403_0201, 1'b0);
        applyStimulus(1'b0, MM_PLANAR, 2'd1, 1'b0, 32'h0403_0201, 1'b0);
        checkOutput("full_rdy", rd_req_rdy, 0);
        checkOutput("full_head", out_data, 32'h0101_0101);
        popOne();
        checkOutput("pop_rdy", rd_req_rdy, 1);
        checkOutput("pop_head", out_data, 32'h0202_0202);
        applyStimulus(1'b0, MM_PLANAR, 2'd2, 1'b0, 32'h0403_0201, 1'b1);
        checkOutput("pushpop_head", out_data, 32'h0303_0303);
        checkOutput("pushpop_rdy", rd_req_rdy, 1);
        applyStimulus(1'b0, MM_PLANAR, 2'd3, 1'b0, 32'h0403_0201, 1'b0);
        checkOutput("refill_rdy", rd_req_rdy, 0);
        checkOutput("refill_head", out_data, 32'h0303_0303);
        popOne();
        checkOutput("order_head", out_data, 32'h0404_0404);
        checkOutput("order_valid", out_valid, 1);

        $display("[TB] reset during wait");
        checkOutput("pre_rst_rdy", rd_req_rdy, 1);
        rd_req = 1'b1;
        @(posedge mem_clk); #1;
        rd_req = 1'b0;
        checkOutput("wait_busy", busy, 1);
        hreset_n = 1'b0;
        #1;
        checkOutput("wrst_busy", busy, 0);
        checkOutput("wrst_out_valid", out_valid, 0);
        checkOutput("wrst_out_data", out_data, 32'h0);
        checkOutput("wrst_cpu_lat", cpu_lat_data, 32'h0);
        checkOutput("wrst_rd_err", rd_err, 0);
        @(posedge mem_clk); #1;
        hreset_n = 1'b1;
        @(posedge mem_clk); #1;
        checkOutput("wrst_rdy", rd_req_rdy, 1);
        mem_rd_data  = 32'h1234_5678;
        mem_rd_valid = 1'b1;
        @(posedge mem_clk); #1;
        mem_rd_valid = 1'b0;
        checkOutput("stray_err", rd_err, 1);
        checkOutput("stray_valid", out_valid, 0);
        checkOutput("stray_lat", cpu_lat_data, 32'h0);
        @(posedge mem_clk); #1;
        checkOutput("err_sticky", rd_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
